// File: rtl/four_by_three_multiplier.sv
// rtl/four_by_three_multiplier.sv - unsigned 4x3 array multiplier, 2-stage pipeline with valid tagging
module four_by_three_multiplier (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [2:0] b,
    input  logic       in_valid,
    output logic [6:0] p,
    output logic       out_valid
);

    // Each cell returns {carry, sum}.
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    logic [3:0] r_a;
    logic [2:0] r_b;
    logic       r_v1;
    logic [6:0] r_p;
    logic       r_out_valid;

    logic [3:0] w_pp0;
    logic [3:0] w_pp1;
    logic [3:0] w_pp2;
    logic [1:0] w_r1_c0;
    logic [1:0] w_r1_c1;
    logic [1:0] w_r1_c2;
    logic [1:0] w_r1_c3;
    logic [1:0] w_r2_c0;
    logic [1:0] w_r2_c1;
    logic [1:0] w_r2_c2;
    logic [1:0] w_r2_c3;
    logic [6:0] w_prod;

    assign w_pp0 = r_a & {4{r_b[0]}};
    assign w_pp1 = r_a & {4{r_b[1]}};
    assign w_pp2 = r_a & {4{r_b[2]}};

    // Row 1 sits one bit left of row 0; the partial sum occupies weights 1..5.
    assign w_r1_c0 = ha(w_pp0[1], w_pp1[0]);
    assign w_r1_c1 = fa(w_pp0[2], w_pp1[1], w_r1_c0[1]);
    assign w_r1_c2 = fa(w_pp0[3], w_pp1[2], w_r1_c1[1]);
    assign w_r1_c3 = ha(w_pp1[3], w_r1_c2[1]);

    // Row 2 adds at weights 2..5; the row-1 carry-out feeds the top cell.
    assign w_r2_c0 = ha(w_r1_c1[0], w_pp2[0]);
    assign w_r2_c1 = fa(w_r1_c2[0], w_pp2[1], w_r2_c0[1]);
    assign w_r2_c2 = fa(w_r1_c3[0], w_pp2[2], w_r2_c1[1]);
    assign w_r2_c3 = fa(w_r1_c3[1], w_pp2[3], w_r2_c2[1]);

    assign w_prod = {w_r2_c3[1], w_r2_c3[0], w_r2_c2[0], w_r2_c1[0],
                     w_r2_c0[0], w_r1_c0[0], w_pp0[0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a  <= 4'd0;
            r_b  <= 3'd0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_a <= a;
                r_b <= b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p         <= 7'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_p <= w_prod;
            end
        end
    end

    assign p         = r_p;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_four_by_three_multiplier.sv
// tb/tb_four_by_three_multiplier.sv - scoreboard bench for four_by_three_multiplier
module tb_four_by_three_multiplier;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'd0;
    logic [2:0] b = 3'd0;
    logic       in_valid = 1'b0;
    logic [6:0] p;
    logic       out_valid;

    four_by_three_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .p         (p),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] prod;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_out = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Products are due at the negedge two rising edges after the driving negedge.
    always @(negedge clk) begin
        exp_t x;
        if (out_valid) begin
            n_checks++;
            n_out++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: got p=%0d at edge %0d, required no output", p, edge_cnt);
            end else begin
                x = sb.pop_front();
                if (p !== x.prod || edge_cnt !== x.due) begin
                    n_fail++;
                    $display("FAIL product: got p=%0d at edge %0d, required p=%0d at edge %0d",
                             p, edge_cnt, x.prod, x.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
            n_checks++;
            n_fail++;
            x = sb.pop_front();
            $display("FAIL missing_out_valid: got out_valid=0 at edge %0d, required p=%0d", edge_cnt, x.prod);
        end
    end

    task automatic step(input logic [3:0] ta, input logic [2:0] tb_, input logic tv,
                        output logic ov_s, output logic [6:0] p_s);
        exp_t x;
        @(negedge clk);
        ov_s = out_valid;
        p_s = p;
        a = ta;
        b = tb_;
        in_valid = tv;
        if (tv && rst_n) begin
            x.prod = 7'(int'(ta) * int'(tb_));
            x.due = edge_cnt + 2;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        logic ov_s;
        logic [6:0] p_s;
        for (int i = 0; i < 4; i++) step(4'd0, 3'd0, 1'b0, ov_s, p_s);
    endtask

    task automatic test_reset();
        logic ov_s;
        logic [6:0] p_s;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (p !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 3'd0, 1'b0, ov_s, p_s);
            n_checks++;
            if (p_s !== 7'd0 || ov_s !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_idle: got p=%0d out_valid=%b, required p=0 out_valid=0", p_s, ov_s);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va[4] = '{4'd3, 4'd12, 4'd9, 4'd8};
        logic [2:0] vb[4] = '{3'd5, 3'd3, 3'd4, 3'd5};
        logic [6:0] pat;
        logic [6:0] last_p;
        logic ov_s;
        logic [6:0] p_s;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(va[i], vb[i], 1'b1, ov_s, p_s);
            else       step(4'd0, 3'd0, 1'b0, ov_s, p_s);
            pat[i] = ov_s;
            if (i == 5) last_p = p_s;
        end
        n_checks++;
        if (pat !== 7'b0111100) begin
            n_fail++;
            $display("FAIL back_to_back_valid: got out_valid pattern %b, required %b", pat, 7'b0111100);
        end
        n_checks++;
        if (last_p !== 7'd40) begin
            n_fail++;
            $display("FAIL back_to_back_last: got p=%0d, required 40", last_p);
        end
        drain();
    endtask

    task automatic test_extremes();
        logic [3:0] va[4] = '{4'd15, 4'd0, 4'd15, 4'd1};
        logic [2:0] vb[4] = '{3'd7, 3'd7, 3'd0, 3'd1};
        logic [6:0] got[6];
        logic ov_s;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(va[i], vb[i], 1'b1, ov_s, got[i]);
            else       step(4'd0, 3'd0, 1'b0, ov_s, got[i]);
        end
        n_checks++;
        if (got[2] !== 7'd105 || got[3] !== 7'd0 || got[4] !== 7'd0 || got[5] !== 7'd1) begin
            n_fail++;
            $display("FAIL extremes: got %0d %0d %0d %0d, required 105 0 0 1", got[2], got[3], got[4], got[5]);
        end
        drain();
    endtask

    task automatic test_valid_gaps();
        logic [5:0] pat;
        logic [6:0] gap_p;
        logic ov_s;
        logic [6:0] p_s;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       step(4'd3, 3'd5, 1'b1, ov_s, p_s);
                1:       step(4'd7, 3'd7, 1'b0, ov_s, p_s);
                2:       step(4'd2, 3'd2, 1'b1, ov_s, p_s);
                default: step(4'd0, 3'd0, 1'b0, ov_s, p_s);
            endcase
            pat[i] = ov_s;
            if (i == 3) gap_p = p_s;
        end
        n_checks++;
        if (pat !== 6'b010100) begin
            n_fail++;
            $display("FAIL gap_valid: got out_valid pattern %b, required %b", pat, 6'b010100);
        end
        n_checks++;
        if (gap_p !== 7'd15) begin
            n_fail++;
            $display("FAIL gap_hold: got p=%0d in gap cycle, required 15", gap_p);
        end
        drain();
    endtask

    task automatic test_midflight_reset();
        logic ov_s;
        logic [6:0] p_s;
        step(4'd9, 3'd4, 1'b1, ov_s, p_s);
        @(negedge clk);
        rst_n = 1'b0;
        a = 4'd5;
        b = 3'd5;
        in_valid = 1'b1;
        while (sb.size() > 0 && sb[sb.size()-1].due > edge_cnt) void'(sb.pop_back());
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || p !== 7'd0) begin
            n_fail++;
            $display("FAIL midflight_kill: got p=%0d out_valid=%b, required p=0 out_valid=0", p, out_valid);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        step(4'd8, 3'd5, 1'b1, ov_s, p_s);
        n_checks++;
        if (ov_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wins: got out_valid=%b, required 0", ov_s);
        end
        step(4'd0, 3'd0, 1'b0, ov_s, p_s);
        n_checks++;
        if (ov_s !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_latency: got out_valid=%b one clk early, required 0", ov_s);
        end
        step(4'd0, 3'd0, 1'b0, ov_s, p_s);
        n_checks++;
        if (ov_s !== 1'b1 || p_s !== 7'd40) begin
            n_fail++;
            $display("FAIL post_reset_product: got p=%0d out_valid=%b, required p=40 out_valid=1", p_s, ov_s);
        end
        drain();
    endtask

    task automatic test_exhaustive();
        logic ov_s;
        logic [6:0] p_s;
        int start_out;
        start_out = n_out;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 8; ib++)
                step(4'(ia), 3'(ib), 1'b1, ov_s, p_s);
        drain();
        n_checks++;
        if (n_out - start_out !== 128) begin
            n_fail++;
            $display("FAIL exhaustive_count: got %0d products, required 128", n_out - start_out);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_extremes();
        test_valid_gaps();
        test_midflight_reset();
        test_exhaustive();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at edge %0d, required completion", edge_cnt);
        $fatal(1);
    end

endmodule
